// File: rtl/barrel_pkg.sv
// ============================================================================
//  Module  : barrel_pkg
//  Brief   : Shared constants, stage record and right-shift helper for the
//            16-bit pipelined right rotator/shifter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_pkg;

  localparam int WIDTH  = 16;
  localparam int CTRL_W = 4;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // The tag is carried next to this record so that its width stays a parameter of the top.
  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  data;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        mode;
  } stage_t;

  // The fill word goes above the data; one right shift covers ROR, SRL and SRA.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] d,
                                                   input int unsigned      s,
                                                   input logic [1:0]       mode);
    logic [2*WIDTH-1:0] w;
    logic [WIDTH-1:0]   fill;
    if (mode == MODE_SRA)      fill = {WIDTH{d[WIDTH-1]}};
    else if (mode == MODE_SRL) fill = '0;
    else                       fill = d;
    w = {fill, d} >> s;
    return w[WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_ror_stage.sv
// ============================================================================
//  Module  : barrel_ror_stage
//  Brief   : One pipeline stage: optional fixed right shift plus register with
//            valid/ready handshake.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_ror_stage
  import barrel_pkg::*;
#(
  parameter int SHIFT = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_t           prev_i,
  input  logic [TAG_W-1:0] prev_tag_i,
  input  logic             shift_en_i,
  input  logic             rdy_next_i,
  output stage_t           stage_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             rdy_o
);

  stage_t           stage_q, stage_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    stage_d = prev_i;
    tag_d   = prev_tag_i;
    if (shift_en_i) begin
      stage_d.data = shift_right(prev_i.data, SHIFT, prev_i.mode);
    end
  end

  // An empty stage always accepts, so bubbles collapse under a downstream stall.
  assign rdy_o = !stage_q.valid | rdy_next_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      tag_q   <= '0;
    end else if (rdy_o) begin
      stage_q.valid <= prev_i.valid;
      if (prev_i.valid) begin
        stage_q <= stage_d;
        tag_q   <= tag_d;
      end
    end
  end

  assign stage_o = stage_q;
  assign tag_o   = tag_q;

endmodule

`default_nettype wire

// File: rtl/barrel_unshift_16bit_pipe.sv
// ============================================================================
//  Module  : barrel_unshift_16bit_pipe
//  Brief   : Four-stage pipelined 16-bit right rotator / logical / arithmetic
//            shifter with valid/ready handshake and sideband tag.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_unshift_16bit_pipe
  import barrel_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  // Index 0 is the input port, index k+1 is the register of stage k.
  stage_t [4:0]            st;
  logic   [4:0][TAG_W-1:0] tg;
  logic   [4:0]            rdy;

  assign st[0].valid = in_valid;
  assign st[0].data  = in_data;
  assign st[0].ctrl  = in_ctrl;
  assign st[0].mode  = in_mode;
  assign tg[0]       = in_tag;
  assign rdy[4]      = out_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_stage
      barrel_ror_stage #(
        .SHIFT (1 << k),
        .TAG_W (TAG_W)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .prev_i     (st[k]),
        .prev_tag_i (tg[k]),
        .shift_en_i (st[k].ctrl[k]),
        .rdy_next_i (rdy[k+1]),
        .stage_o    (st[k+1]),
        .tag_o      (tg[k+1]),
        .rdy_o      (rdy[k])
      );
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = st[4].valid;
  assign out_data  = st[4].data;
  assign out_tag   = tg[4];

  logic unused_ok;
  assign unused_ok = ^{st[4].ctrl, st[4].mode};

endmodule

`default_nettype wire

// File: tb/tb_barrel_unshift_16bit_pipe.sv
// ============================================================================
//  Module  : tb_barrel_unshift_16bit_pipe
//  Brief   : Directed self-checking bench for barrel_unshift_16bit_pipe.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_unshift_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_ctrl;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int n_chk = 0;
  int n_err = 0;
  int n_rx  = 0;

  logic [15:0] exp_data[$];
  logic [3:0]  exp_tag[$];

  logic        hold_valid = 1'b0;
  logic [15:0] hold_data;
  logic [3:0]  hold_tag;

  barrel_unshift_16bit_pipe #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_rx++;
        if (exp_data.size() == 0) begin
          chk("unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("out_data", {16'h0, out_data}, {16'h0, exp_data.pop_front()});
          chk("out_tag", {28'h0, out_tag}, {28'h0, exp_tag.pop_front()});
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_valid) begin
          chk("stall_data", {16'h0, out_data}, {16'h0, hold_data});
          chk("stall_tag", {28'h0, out_tag}, {28'h0, hold_tag});
        end
        hold_valid <= 1'b1;
        hold_data  <= out_data;
        hold_tag   <= out_tag;
      end else begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Presents one word and returns one time unit after the edge that accepts it.
  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] m,
                      input logic [3:0] t, input logic [15:0] e);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    in_mode  = m;
    in_tag   = t;
    exp_data.push_back(e);
    exp_tag.push_back(t);
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(waited), 32'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while (exp_data.size() != 0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    chk(tag, 32'(exp_data.size()), 32'd0);
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] d, input int s);
    logic [31:0] w;
    w = {d, d} << s;
    return w[31:16];
  endfunction

  initial begin
    int rx0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    in_ctrl   = 4'd3;
    in_mode   = 2'b00;
    in_tag    = 4'hF;
    out_ready = 1'b1;

    // Reset held with in_valid asserted: nothing may come out.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {16'h0, out_data}, 32'd0);
    chk("rst_out_tag", {28'h0, out_tag}, 32'd0);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_no_output", 32'(n_rx), 32'd0);
    @(posedge clk);
    #1;

    // ROR first vector with latency check.
    send(16'h4001, 4'd1, 2'b00, 4'd1, 16'hA000);
    idle();
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", n), {31'h0, out_valid}, (n == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'h4001, 4'd15, 2'b00, 4'd2,  16'h8002);
    send(16'h4001, 4'd0,  2'b00, 4'd3,  16'h4001);
    send(16'h1234, 4'd4,  2'b00, 4'd4,  16'h4123);
    // SRL / SRA / mode 11.
    send(16'h8001, 4'd1,  2'b01, 4'd5,  16'h4000);
    send(16'h8001, 4'd1,  2'b10, 4'd6,  16'hC000);
    send(16'h8000, 4'd15, 2'b10, 4'd7,  16'hFFFF);
    send(16'h8001, 4'd1,  2'b11, 4'd8,  16'hC000);
    send(16'h8000, 4'd15, 2'b01, 4'd9,  16'h0001);
    send(16'h7FFF, 4'd4,  2'b10, 4'd10, 16'h07FF);
    send(16'h8001, 4'd0,  2'b10, 4'd11, 16'h8001);
    send(16'hABCD, 4'd8,  2'b01, 4'd12, 16'h00AB);
    send(16'hF000, 4'd6,  2'b10, 4'd13, 16'hFFC0);
    idle();
    drain("drain_directed");

    // Round trip against a left rotation by the same amount.
    @(posedge clk);
    #1;
    rx0 = n_rx;
    for (int c = 0; c < 16; c++) begin
      send(rotl(16'd16385, c), 4'(c), 2'b00, 4'(c), 16'd16385);
    end
    idle();
    drain("drain_roundtrip");
    chk("roundtrip_count", 32'(n_rx - rx0), 32'd16);

    // Backpressure: out_ready low in cycles 6..12 of a 16-word stream.
    @(posedge clk);
    #1;
    rx0 = n_rx;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(16'(i) * 16'h1111 + 16'h0101, 4'd0, 2'b00, 4'(i), 16'(i) * 16'h1111 + 16'h0101);
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
        chk("bp_out_valid_held", {31'h0, out_valid}, 32'd1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk("bp_count", 32'(n_rx - rx0), 32'd16);

    // Reset with three words in flight, the oldest already at the output.
    @(posedge clk);
    #1;
    send(16'h1111, 4'd0, 2'b00, 4'd1, 16'h1111);
    send(16'h2222, 4'd0, 2'b00, 4'd2, 16'h2222);
    send(16'h3333, 4'd0, 2'b00, 4'd3, 16'h3333);
    idle();
    @(posedge clk);
    #1;
    chk("mid_out_valid_before", {31'h0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid_async", {31'h0, out_valid}, 32'd0);
    chk("mid_out_data_async", {16'h0, out_data}, 32'd0);
    exp_data.delete();
    exp_tag.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx0 = n_rx;
    send(16'h5A5A, 4'd4, 2'b01, 4'd9, 16'h05A5);
    idle();
    drain("drain_post_reset");
    repeat (6) @(negedge clk);
    chk("post_reset_count", 32'(n_rx - rx0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
